// File: rtl/button_load_ctrl.sv
// Four-button front end: synchronize, debounce, latch press requests and grant
// them one at a time to register slots through a round-robin arbiter.
module button_load_ctrl #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] load,
  output logic [1:0] load_idx,
  output logic [3:0] pending,
  output logic       busy
);

  localparam logic [7:0] DbLast   = 8'(DB_CYCLES - 1);
  localparam logic [7:0] HoldLast = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StHold} arbState;

  arbState    state;
  logic [3:0] btnMeta;
  logic [3:0] btnSync;
  logic [3:0] stable;
  logic [7:0] dbCnt [4];
  logic [3:0] flipMask;
  logic [3:0] riseMask;
  logic [3:0] clrMask;
  logic [7:0] holdCnt;
  logic [1:0] ptr;
  logic [1:0] idx;
  logic [1:0] nextIdx;
  logic [1:0] cand;
  logic       found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnMeta <= '0;
      btnSync <= '0;
    end else begin
      btnMeta <= btn;
      btnSync <= btnMeta;
    end
  end

  always_comb begin
    flipMask = '0;
    for (int i = 0; i < 4; i++) begin
      flipMask[i] = (btnSync[i] != stable[i]) && (dbCnt[i] == DbLast);
    end
    riseMask = flipMask & btnSync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btnSync[i] == stable[i]) begin
          dbCnt[i] <= '0;
        end else if (flipMask[i]) begin
          stable[i] <= ~stable[i];
          dbCnt[i]  <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + 8'd1;
        end
      end
    end
  end

  // Round-robin search starting at ptr.
  always_comb begin
    nextIdx = ptr;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && pending[cand]) begin
        nextIdx = cand;
        found   = 1'b1;
      end
    end
  end

  // A new press on the grant-exit edge overrides the clear.
  always_comb begin
    clrMask = '0;
    if (state == StGrant) clrMask = 4'b0001 << idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clrMask) | riseMask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      load     <= '0;
      load_idx <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      idx      <= '0;
      holdCnt  <= '0;
    end else begin
      case (state)
        StIdle: begin
          load     <= '0;
          load_idx <= '0;
          busy     <= 1'b0;
          if (|pending) begin
            idx      <= nextIdx;
            load     <= 4'b0001 << nextIdx;
            load_idx <= nextIdx;
            busy     <= 1'b1;
            state    <= StGrant;
          end
        end
        StGrant: begin
          load     <= '0;
          load_idx <= '0;
          ptr      <= idx + 2'd1;
          holdCnt  <= HoldLast;
          state    <= StHold;
        end
        StHold: begin
          if (holdCnt == 8'd0) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            holdCnt <= holdCnt - 8'd1;
          end
        end
        default: begin
          load     <= '0;
          load_idx <= '0;
          busy     <= 1'b0;
          state    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_load_ctrl.sv
// Randomized bench for button_load_ctrl against a timing-level reference model.
module tb_button_load_ctrl;

  localparam int DB = 4;
  localparam int HO = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] load;
  logic [1:0] load_idx;
  logic [3:0] pending;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_load_ctrl #(
    .DB_CYCLES(DB),
    .HOLDOFF  (HO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .load    (load),
    .load_idx(load_idx),
    .pending (pending),
    .busy    (busy)
  );

  // Model state: raw sample history plus event times instead of counters/FSM.
  logic [3:0] hist[$];
  logic [3:0] mStable, mPending, mLoad;
  logic [1:0] mLoadIdx, mPtr, clrIdx;
  logic       mBusy;
  int         n, nextFree, lastGrant, clearAt;
  int         lastFlip[4];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    for (int k = 0; k < DB + 4; k++) hist.push_back(4'b0000);
    mStable   = '0;
    mPending  = '0;
    mLoad     = '0;
    mLoadIdx  = '0;
    mPtr      = '0;
    mBusy     = 1'b0;
    n         = 0;
    nextFree  = 1;
    lastGrant = -1000;
    clearAt   = -1;
    clrIdx    = '0;
    for (int i = 0; i < 4; i++) lastFlip[i] = 0;
  endtask

  // Edge n: button level seen by the debouncer is the raw sample from edge n-2.
  // A level flips once DB consecutive edges saw it differ, DB edges after the last flip.
  task automatic modelStep(input logic [3:0] b);
    logic [3:0] setMask, oldPend, newPend, s, dummy;
    logic [1:0] c;
    bit         allDiff, got;
    n++;
    hist.push_front(b);
    dummy = hist.pop_back();
    setMask = '0;
    for (int i = 0; i < 4; i++) begin
      allDiff = 1'b1;
      for (int k = 0; k < DB; k++) begin
        s = hist[2 + k];
        if (s[i] == mStable[i]) allDiff = 1'b0;
      end
      if (allDiff && (n - lastFlip[i] >= DB)) begin
        mStable[i]  = ~mStable[i];
        lastFlip[i] = n;
        if (mStable[i]) setMask[i] = 1'b1;
      end
    end
    oldPend = mPending;
    newPend = oldPend;
    if (n == clearAt) newPend[clrIdx] = 1'b0;
    newPend  = newPend | setMask;
    mLoad    = '0;
    mLoadIdx = '0;
    if (n >= nextFree && oldPend != 4'b0000) begin
      got = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = mPtr + 2'(k);
        if (!got && oldPend[c]) begin
          got      = 1'b1;
          mLoadIdx = c;
        end
      end
      mLoad     = 4'b0001 << mLoadIdx;
      lastGrant = n;
      nextFree  = n + HO + 2;
      clearAt   = n + 1;
      clrIdx    = mLoadIdx;
      mPtr      = mLoadIdx + 2'd1;
    end
    mBusy    = (n >= lastGrant) && (n <= lastGrant + HO);
    mPending = newPend;
  endtask

  task automatic step(input logic [3:0] b);
    btn = b;
    @(posedge clk);
    modelStep(b);
    #1;
    checkVal("load", load, mLoad);
    checkVal("load_idx", load_idx, mLoadIdx);
    checkVal("pending", pending, mPending);
    checkVal("busy", busy, mBusy);
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, "_load"}, load, 4'b0000);
    checkVal({tag, "_load_idx"}, load_idx, 2'b00);
    checkVal({tag, "_pending"}, pending, 4'b0000);
    checkVal({tag, "_busy"}, busy, 1'b0);
  endtask

  // Called just after a rising edge; asserts rst between edges.
  task automatic pulseReset(input int hold);
    #2 rst = 1'b1;
    #1 checkZero("rst_async");
    modelReset();
    repeat (hold) @(posedge clk);
    #1 checkZero("rst_hold");
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn = 4'b0000;
    modelReset();
    #1 checkZero("reset");
    @(posedge clk);
    #1;
    pulseReset(2);

    // Single Up press, then release.
    repeat (20) step(4'b0001);
    repeat (10) step(4'b0000);
    // Short glitch on Right, never debounced.
    repeat (3) step(4'b0010);
    repeat (12) step(4'b0000);

    // Up+Down together from reset, then Left+Up with ptr at 3.
    @(posedge clk);
    #1;
    pulseReset(1);
    repeat (20) step(4'b0101);
    repeat (10) step(4'b0000);
    repeat (20) step(4'b1001);
    repeat (10) step(4'b0000);

    // Bouncing Down, then held, released, pressed again.
    for (int i = 0; i < 10; i++) step((i % 2) ? 4'b0100 : 4'b0000);
    repeat (12) step(4'b0100);
    repeat (8) step(4'b0000);
    repeat (12) step(4'b0100);
    repeat (8) step(4'b0000);

    // Coalescing: Down re-pressed while the arbiter is kept busy by others.
    repeat (12) step(4'b1111);
    repeat (5) step(4'b1011);
    repeat (8) step(4'b1111);
    repeat (20) step(4'b0000);

    // Reset during HOLD with requests still pending.
    @(posedge clk);
    #1;
    pulseReset(1);
    repeat (8) step(4'b1010);
    pulseReset(2);
    repeat (20) step(4'b0000);

    // Randomized levels with occasional bounce bursts and resets.
    begin
      logic [3:0] lvl;
      lvl = 4'b0000;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 11) == 0) lvl[i] = ~lvl[i];
        end
        if ($urandom_range(0, 400) == 0) begin
          pulseReset(int'($urandom_range(1, 3)));
        end else if ($urandom_range(0, 5) == 0) begin
          step(lvl ^ 4'($urandom_range(0, 15)));
        end else begin
          step(lvl);
        end
      end
    end
    repeat (30) step(4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_load_ctrl.md
BUTTON_LOAD_CTRL -- requirements
Module: button_load_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive cycles a synchronized button must hold a new level before the debounced level changes; legal range 2..255.
REQ-002 Parameter HOLDOFF, default 4: cycles spent in HOLD after each grant; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn  input  4  raw push-buttons: [0]=Up, [1]=Right, [2]=Down, [3]=Left; asynchronous and bouncing.
REQ-006 load  output  4  one-hot, single-cycle load strobe to register slot 0..3.
REQ-007 load_idx  output  2  index of the slot being loaded; valid only while load != 0, else 0.
REQ-008 pending  output  4  registered press requests not yet granted.
REQ-009 busy  output  1  high while the arbiter is in GRANT or HOLD.

Function
REQ-010 Each btn bit passes through a 2-flop synchronizer (btn_sync = btn sampled two edges earlier) before any other use.
REQ-011 Per button: a debounce counter increments each edge while btn_sync != stable, clears to 0 on any edge where btn_sync == stable.
REQ-012 stable flips, and the counter clears, on the edge where btn_sync still differs and the counter equals DB_CYCLES-1 (i.e. after DB_CYCLES consecutive differing edges).
REQ-013 A 0->1 flip of stable[i] sets pending[i] on the same edge; 1->0 flips have no effect beyond updating stable.
REQ-014 A new press on a bit already pending coalesces: no count, no extra grant.
REQ-015 Arbiter FSM states: IDLE, GRANT, HOLD; 2-bit round-robin pointer ptr.
REQ-016 IDLE: busy=0, load=0; if pending != 0, latch idx = first set bit searching ptr, ptr+1, ... mod 4, go to GRANT next edge; else stay.
REQ-017 GRANT (exactly one cycle): load = one-hot(idx), load_idx = idx, busy=1; on leaving: pending[idx] cleared, ptr = (idx+1) mod 4, hold counter loaded with HOLDOFF-1, next state HOLD.
REQ-018 HOLD: busy=1, load=0; counter decrements each edge; at counter 0 go to IDLE next edge.
REQ-019 Grant spacing with back-to-back requests is HOLDOFF+2 cycles (GRANT + HOLDOFF + IDLE).
REQ-020 Simultaneous set and clear of pending[idx] on the GRANT exit edge: set wins (request retained).
REQ-021 Presses arriving in GRANT or HOLD are recorded in pending and served after HOLD; none are dropped.
REQ-022 Latency, arbiter idle, btn[i] held high: first edge sampling btn[i]=1 is edge 1; stable[i] and pending[i] set at edge DB_CYCLES+2; load[i] high for the single cycle following edge DB_CYCLES+3.
REQ-023 At most one load bit is high in any cycle; load and load_idx are registered (glitch-free).

Reset
REQ-024 While rst=1, immediately and independent of clk: load=0, load_idx=0, pending=0, busy=0, state=IDLE, ptr=0, all synchronizer flops, stable bits and counters = 0.
REQ-025 rst asserted mid-GRANT truncates the strobe at once; no partial grant is resumed after release.
REQ-026 A button held across rst release is treated as a new press (stable starts at 0) and is granted after normal debounce.

Verification (DB_CYCLES=4, HOLDOFF=2)
REQ-027 btn=0001 held 20 cycles from reset -> load=0001, load_idx=0 exactly one cycle after edge 7; busy high edges 7..10; no strobe on release.
REQ-028 btn[1] pulsed high 3 cycles then low -> stable[1], pending and load remain 0 throughout.
REQ-029 btn=0101 asserted together from reset -> load=0001 after edge 7, load=0100 after edge 11; pending 0101 -> 0100 -> 0000.
REQ-030 After REQ-029 (ptr=3), btn=1001 pressed together -> Left (load=1000) granted first, then Up (0001), 4 cycles apart.
REQ-031 btn[2] bounced 0/1 every cycle for 10 cycles then held high -> exactly one load=0100 strobe; second press while pending[2]=1 -> still one strobe.
REQ-032 rst pulsed during HOLD with pending=1010 -> outputs all 0 asynchronously, ptr=0; with btn=0 after release, no strobe ever issues.
